// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte FIFO behind the UART receiver with valid/ready drain, overrun and level irq
module uart_rx_fifo #(
    parameter int DataWidth = 8,
    parameter int Depth     = 16,
    localparam int PtrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_dv_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic                 rd_ready_i,
    output logic                 rd_valid_o,
    output logic [DataWidth-1:0] rd_data_o,
    output logic [PtrWidth:0]    count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 overrun_o,
    input  logic                 overrun_clr_i,
    input  logic [PtrWidth:0]    thresh_i,
    output logic                 irq_o
);
    logic [DataWidth-1:0] mem [Depth];
    logic [PtrWidth:0]    wr_ptr, rd_ptr;
    logic                 pop, push, drop;

    assign empty_o    = wr_ptr == rd_ptr;
    assign full_o     = (wr_ptr[PtrWidth] != rd_ptr[PtrWidth]) &&
                        (wr_ptr[PtrWidth-1:0] == rd_ptr[PtrWidth-1:0]);
    assign count_o    = wr_ptr - rd_ptr;
    assign rd_valid_o = !empty_o;
    assign rd_data_o  = empty_o ? '0 : mem[rd_ptr[PtrWidth-1:0]];
    assign irq_o      = (thresh_i != '0) && (count_o >= thresh_i);
    assign pop        = rd_valid_o && rd_ready_i;
    assign push       = wr_dv_i && (!full_o || pop);
    assign drop       = wr_dv_i && full_o && !pop;

    // storage is unreset; contents are meaningless once the pointers are cleared
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[PtrWidth-1:0]] <= wr_data_i;
    end

    // pointers advance on accepted push/pop; overrun is sticky and a drop beats a clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            overrun_o <= drop ? 1'b1 : overrun_clr_i ? 1'b0 : overrun_o;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
    logic       clk_i = 0, rst_ni = 0;
    logic       wr_dv_i = 0, rd_ready_i = 0, overrun_clr_i = 0;
    logic [7:0] wr_data_i = 0;
    logic [4:0] thresh_i = 0;
    logic       rd_valid_o, full_o, empty_o, overrun_o, irq_o;
    logic [7:0] rd_data_o;
    logic [4:0] count_o;

    int checks = 0, errors = 0;
    logic [7:0] exp_q [$];
    logic       m_ov = 0;

    uart_rx_fifo dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wr_dv_i(wr_dv_i), .wr_data_i(wr_data_i),
        .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .overrun_o(overrun_o),
        .overrun_clr_i(overrun_clr_i), .thresh_i(thresh_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        int n = exp_q.size();
        check("count", count_o, n);
        check("empty", empty_o, n == 0);
        check("full", full_o, n == 16);
        check("valid", rd_valid_o, n != 0);
        check("data", rd_data_o, n != 0 ? exp_q[0] : 8'h00);
        check("overrun", overrun_o, m_ov);
        check("irq", irq_o, thresh_i != 0 && n >= thresh_i);
    endtask

    task automatic cycle(input logic dv, input logic [7:0] d, input logic rdy, input logic clr);
        bit full = exp_q.size() == 16;
        bit pop = rdy && exp_q.size() != 0;
        logic [7:0] h;
        if (pop) begin
            h = exp_q.pop_front();
            check("pop_data", rd_data_o, h);
        end
        if (dv && (!full || pop)) exp_q.push_back(d);
        m_ov = (dv && full && !pop) ? 1'b1 : clr ? 1'b0 : m_ov;
        wr_dv_i = dv; wr_data_i = d; rd_ready_i = rdy; overrun_clr_i = clr;
        @(posedge clk_i); #1;
        wr_dv_i = 0; rd_ready_i = 0; overrun_clr_i = 0;
        check_state();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(0, 0, 1, 0);
        check("drained", empty_o, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1 check_state();
        rst_ni = 1;
        for (int i = 0; i < 5; i++) cycle(1, 8'hC0 + 8'(i), 0, 0);
        #2 rst_ni = 0;
        #1;
        exp_q.delete(); m_ov = 0;
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_valid", rd_valid_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_data", rd_data_o, 0);
        #1 rst_ni = 1;
        @(posedge clk_i); #1 check_state();
        cycle(1, 8'h11, 0, 0); cycle(0, 0, 0, 0);
        cycle(1, 8'h22, 0, 0); cycle(0, 0, 0, 0);
        cycle(1, 8'h33, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        check("order_empty", empty_o, 1);
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0);
        check("fill_full", full_o, 1);
        check("fill_count", count_o, 16);
        cycle(1, 8'hAA, 0, 0);
        check("drop_overrun", overrun_o, 1);
        drain();
        cycle(0, 0, 0, 1);
        check("ov_cleared", overrun_o, 0);
        for (int i = 0; i < 16; i++) cycle(1, 8'h30 + 8'(i), 0, 0);
        cycle(1, 8'h55, 1, 0);
        check("fullpp_count", count_o, 16);
        check("fullpp_ov", overrun_o, 0);
        drain();
        for (int i = 0; i < 40; i++)
            cycle(i % 3 != 2, 8'h80 + 8'(i), ((i / 8) % 2 == 1) ? 1'b1 : (i % 4 == 0), 0);
        drain();
        thresh_i = 4;
        for (int i = 0; i < 3; i++) cycle(1, 8'h40 + 8'(i), 0, 0);
        check("irq_3", irq_o, 0);
        cycle(1, 8'h43, 0, 0);
        check("irq_4", irq_o, 1);
        cycle(0, 0, 1, 0);
        check("irq_pop", irq_o, 0);
        thresh_i = 0;
        for (int i = 0; i < 13; i++) cycle(1, 8'h50 + 8'(i), 0, 0);
        check("irq_dis_full", full_o, 1);
        check("irq_dis", irq_o, 0);
        thresh_i = 16;
        #1 check("irq_16", irq_o, 1);
        cycle(1, 8'hEE, 0, 1);
        check("ov_set_wins", overrun_o, 1);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. It captures each byte the receiver flags with its one-cycle data-valid strobe and holds it in a circular FIFO. The FIFO drains through a valid/ready read port toward the bus/CPU side. It reports fill level, full/empty, a sticky overrun flag and a level-threshold interrupt.

## Interface
- DataWidth, 8, byte width; matches the receiver's data width
- Depth, 16, number of entries; power of two, ≥ 2
- PtrWidth (localparam), $clog2(Depth), index width; pointers are PtrWidth+1 bits
- clk_i  input  1  system clock; all state updates on its rising edge
- rst_ni  input  1  asynchronous active-low reset
- wr_dv_i  input  1  one-cycle strobe from receiver: byte on wr_data_i is valid
- wr_data_i  input  DataWidth  received byte
- rd_ready_i  input  1  consumer accepts the head entry this cycle
- rd_valid_o  output  1  head entry present (= !empty_o)
- rd_data_o  output  DataWidth  head entry; '0 when empty
- count_o  output  PtrWidth+1  current number of stored entries, 0..Depth
- full_o  output  1  count_o == Depth
- empty_o  output  1  count_o == 0
- overrun_o  output  1  sticky: a byte was dropped because the FIFO was full
- overrun_clr_i  input  1  synchronous clear of overrun_o
- thresh_i  input  PtrWidth+1  interrupt level; 0 disables
- irq_o  output  1  (thresh_i != 0) && (count_o >= thresh_i)

## Operation
- Storage: Depth x DataWidth register array, no reset on contents; wr_ptr/rd_ptr are PtrWidth+1 bits and wrap naturally modulo 2*Depth; the index is the low PtrWidth bits.
- count = wr_ptr - rd_ptr (PtrWidth+1-bit modular subtraction); full when MSBs differ and indices equal; empty when pointers are equal.
- pop = rd_valid_o && rd_ready_i. On a pop, rd_ptr increments. rd_ready_i while empty is ignored.
- push = wr_dv_i && (!full || pop). On a push, mem[wr_ptr] <= wr_data_i and wr_ptr increments.
- Full with simultaneous pop and write: both happen; count stays Depth; no overrun.
- Drop = wr_dv_i && full && !pop. The byte is discarded, pointers are unchanged and overrun_o is set.
- overrun_o: set by a drop; cleared by overrun_clr_i; set wins if both occur in the same cycle.
- Simultaneous push and pop when not empty/full: count unchanged, both pointers advance.
- Read port is show-ahead: rd_data_o = mem[rd_ptr[PtrWidth-1:0]] whenever not empty.
- No write-through: a byte pushed into an empty FIFO is not visible on the read port in the cycle it is pushed.
- rd_valid_o, full_o, empty_o, count_o, irq_o are combinational from the registered pointers and thresh_i; overrun_o is a register.
- Reset (asynchronous, any time, including mid-stream): pointers 0, overrun_o 0. Outputs then: rd_valid_o 0, empty_o 1, full_o 0, count_o 0, rd_data_o '0, irq_o 0. All stored contents are considered lost.

## Timing
- Write latency: wr_dv_i sampled at edge N; from edge N onward rd_valid_o=1, count_o incremented, rd_data_o shows the byte (if the FIFO was empty).
- Pop: handshake sampled at edge N; the next entry (or empty) is visible after edge N.
- Throughput: one push and one pop per cycle sustained; the receiver strobes far slower than this.
- irq_o follows count_o with zero added latency; it deasserts in the cycle after the pop that drops count below thresh_i.
- overrun_o rises the cycle after the dropping edge and stays high until cleared.

## Test plan
- Reset/idle: assert rst_ni=0 mid-operation with count=5 -> immediately count_o=0, empty_o=1, rd_valid_o=0, overrun_o=0, rd_data_o=0.
- Ordering: push 0x11,0x22,0x33 on separate strobes, then hold rd_ready_i=1 -> reads 0x11,0x22,0x33 in order, one per cycle, then empty_o=1.
- Fill and overrun (Depth=16): push 0x00..0x0F -> full_o=1, count_o=16. Push 0xAA -> dropped, overrun_o=1. Drain -> 0x00..0x0F, no 0xAA. Pulse overrun_clr_i -> overrun_o=0.
- Full with simultaneous push+pop: at full, wr_dv_i=1 with 0x55 and rd_ready_i=1 -> head popped, 0x55 stored last, count_o stays 16, overrun_o stays 0.
- Pointer wrap: 40 push/pop cycles of incrementing bytes at mixed fill levels -> scoreboard matches with no loss or duplication; count_o always matches the model.
- Threshold: thresh_i=4. Push 3 -> irq_o=0; push 4th -> irq_o=1; pop 1 -> irq_o=0. Set thresh_i=0 with 16 entries -> irq_o=0. Clear and set overrun in the same cycle -> overrun_o=1.
